// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMEM = 2'b11;

    localparam int MD_CNT_W = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard detection, operand forwarding, mult/div occupancy tracking
// and stall-cycle accounting for the five-stage pipeline.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             usert,
    input  logic             dmd,
    input  logic             dmduse,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             dbubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [MD_CNT_W-1:0] MD_LAT_C = MD_CNT_W'(MD_LAT);

    md_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic e_alu_valid;
    logic e_load_valid;
    logic m_valid;
    logic load_use;
    logic md_hazard;
    logic stall;
    logic md_issue;

    // A loaded value in E cannot be forwarded yet; only ALU results qualify.
    assign e_alu_valid  = ewreg && !em2reg && (ern != 5'd0);
    assign e_load_valid = ewreg &&  em2reg && (ern != 5'd0);
    assign m_valid      = mwreg && (mrn != 5'd0);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fwda = FWD_RF;
        if (e_alu_valid && (ern == rs)) begin
            fwda = FWD_EALU;
        end else if (m_valid && (mrn == rs)) begin
            fwda = mm2reg ? FWD_MMEM : FWD_MALU;
        end
    end

    always_comb begin
        fwdb = FWD_RF;
        if (e_alu_valid && (ern == rt)) begin
            fwdb = FWD_EALU;
        end else if (m_valid && (mrn == rt)) begin
            fwdb = mm2reg ? FWD_MMEM : FWD_MALU;
        end
    end

    assign load_use  = e_load_valid && ((ern == rs) || (usert && (ern == rt)));
    assign md_busy   = (md_cnt_q != '0);
    assign md_hazard = md_busy && (dmd || dmduse);
    assign stall     = load_use || md_hazard;
    assign wpcir     = !stall;
    assign dbubble   = stall;
    assign md_issue  = dmd && wpcir;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_issue) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LAT_C;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q > 4'd1) begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end else if (md_issue) begin
                    // Back-to-back issue on the final busy cycle keeps the unit occupied.
                    md_cnt_d = MD_LAT_C;
                end else begin
                    md_cnt_d = '0;
                    state_d  = MD_IDLE;
                end
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .en     (stall),
        .cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit; a narrow-counter instance exercises saturation.
module tb_pipe_hazard_unit;

    logic        clock;
    logic        resetn;
    logic [4:0]  rs, rt, ern, mrn;
    logic        usert, dmd, dmduse, ewreg, em2reg, mwreg, mm2reg;
    logic [1:0]  fwda, fwdb, fwda_s, fwdb_s;
    logic        wpcir, dbubble, md_busy, wpcir_s, dbubble_s, md_busy_s;
    logic [31:0] stall_cnt;
    logic [2:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;

    pipe_hazard_unit #(.MD_LAT(4), .CNT_W(32)) dut (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .usert(usert),
        .dmd(dmd), .dmduse(dmduse), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda), .fwdb(fwdb),
        .wpcir(wpcir), .dbubble(dbubble), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_unit #(.MD_LAT(4), .CNT_W(3)) dut_small (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .usert(usert),
        .dmd(dmd), .dmduse(dmduse), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda_s), .fwdb(fwdb_s),
        .wpcir(wpcir_s), .dbubble(dbubble_s), .md_busy(md_busy_s), .stall_cnt(stall_cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rs = 5'd0; rt = 5'd0; usert = 1'b0; dmd = 1'b0; dmduse = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
        mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, and combinational hazard terms still visible under reset.
        resetn = 1'b0;
        clear_inputs();
        #2;
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_wpcir", 32'(wpcir), 32'd1);
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; rs = 5'd8;
        #1;
        check("rst_comb_wpcir", 32'(wpcir), 32'd0);
        check("rst_comb_dbubble", 32'(dbubble), 32'd1);
        cycle();
        check("rst_cnt_held", stall_cnt, 32'd0);
        clear_inputs();
        resetn = 1'b1;
        cycle();

        // E ALU forwarding on both operands.
        ewreg = 1'b1; em2reg = 1'b0; ern = 5'd5; rs = 5'd5; rt = 5'd5; usert = 1'b1;
        #1;
        check("e_fwda", 32'(fwda), 32'd1);
        check("e_fwdb", 32'(fwdb), 32'd1);
        check("e_wpcir", 32'(wpcir), 32'd1);
        check("e_dbubble", 32'(dbubble), 32'd0);
        cycle();

        // M ALU forwarding on rs, no match on rt.
        clear_inputs();
        mwreg = 1'b1; mm2reg = 1'b0; mrn = 5'd7; rs = 5'd7; rt = 5'd9; usert = 1'b1;
        #1;
        check("m_fwda", 32'(fwda), 32'd2);
        check("m_fwdb", 32'(fwdb), 32'd0);
        cycle();

        // E over M priority; fwdb ignores usert.
        clear_inputs();
        ewreg = 1'b1; ern = 5'd6; mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd6;
        rs = 5'd6; rt = 5'd6; usert = 1'b0;
        #1;
        check("prio_fwda", 32'(fwda), 32'd1);
        check("prio_fwdb", 32'(fwdb), 32'd1);
        cycle();

        // Register 0 never forwards and never stalls.
        clear_inputs();
        ewreg = 1'b1; ern = 5'd0; mwreg = 1'b1; mrn = 5'd0; usert = 1'b1;
        #1;
        check("r0_fwda", 32'(fwda), 32'd0);
        check("r0_fwdb", 32'(fwdb), 32'd0);
        em2reg = 1'b1;
        #1;
        check("r0_load_wpcir", 32'(wpcir), 32'd1);
        cycle();

        // Load to rt without usert: no stall, no forward from E load.
        clear_inputs();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rs = 5'd1; rt = 5'd3; usert = 1'b0;
        #1;
        check("rt_nouse_wpcir", 32'(wpcir), 32'd1);
        check("rt_nouse_fwdb", 32'(fwdb), 32'd0);
        cycle();
        check("rt_nouse_cnt", stall_cnt, 32'd0);

        // Load-use on rs: one stall cycle, then M memory forwarding.
        clear_inputs();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; rs = 5'd8; rt = 5'd2; usert = 1'b1;
        #1;
        check("lu_wpcir", 32'(wpcir), 32'd0);
        check("lu_dbubble", 32'(dbubble), 32'd1);
        check("lu_fwda", 32'(fwda), 32'd0);
        cycle();
        check("lu_cnt", stall_cnt, 32'd1);
        clear_inputs();
        mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd8; rs = 5'd8; rt = 5'd2; usert = 1'b1;
        #1;
        check("lu_next_fwda", 32'(fwda), 32'd3);
        check("lu_next_wpcir", 32'(wpcir), 32'd1);
        cycle();
        check("lu_next_cnt", stall_cnt, 32'd1);

        // Mult/div issue accepted in cycle T, dependent mfhi stalls T+1..T+4.
        clear_inputs();
        dmd = 1'b1;
        #1;
        check("md_issue_wpcir", 32'(wpcir), 32'd1);
        check("md_issue_busy", 32'(md_busy), 32'd0);
        cycle();
        dmd = 1'b0; dmduse = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("md_busy_t%0d", i), 32'(md_busy), 32'd1);
            check($sformatf("md_wpcir_t%0d", i), 32'(wpcir), 32'd0);
            cycle();
        end
        check("md_after_busy", 32'(md_busy), 32'd0);
        check("md_after_wpcir", 32'(wpcir), 32'd1);
        check("md_cnt", stall_cnt, 32'd5);
        check("md_cnt_small", 32'(stall_cnt_s), 32'd5);

        // Re-issue at T'; then load-use and MD hazard together for three cycles.
        dmduse = 1'b0; dmd = 1'b1;
        #1;
        check("md2_issue_wpcir", 32'(wpcir), 32'd1);
        cycle();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd4; rs = 5'd4;
        #1;
        check("both_wpcir", 32'(wpcir), 32'd0);
        check("both_dbubble", 32'(dbubble), 32'd1);
        cycle();
        check("both_cnt1", stall_cnt, 32'd6);
        cycle();
        check("both_cnt2", stall_cnt, 32'd7);
        cycle();
        check("both_cnt3", stall_cnt, 32'd8);
        check("sat_small", 32'(stall_cnt_s), 32'd7);

        // Reset pulse on the last busy cycle releases the MD stall at once.
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0; rs = 5'd0;
        #1;
        check("prerst_busy", 32'(md_busy), 32'd1);
        check("prerst_wpcir", 32'(wpcir), 32'd0);
        resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(md_busy), 32'd0);
        check("midrst_wpcir", 32'(wpcir), 32'd1);
        check("midrst_cnt", stall_cnt, 32'd0);
        check("midrst_cnt_small", 32'(stall_cnt_s), 32'd0);
        cycle();
        dmd = 1'b0;
        resetn = 1'b1;
        cycle();
        check("postrst_busy", 32'(md_busy), 32'd0);
        check("postrst_cnt", stall_cnt, 32'd0);

        // FSM idle after release: a fresh issue is accepted and occupies the unit.
        dmd = 1'b1;
        #1;
        check("postrst_issue_wpcir", 32'(wpcir), 32'd1);
        cycle();
        dmd = 1'b0;
        #1;
        check("postrst_issue_busy", 32'(md_busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
